// File: rtl/time_counter.sv
// BCD current-time keeper: four digit registers advanced by one_minute, loaded by load_new_c.
// Define TIME_12HR_EN for 12-hour mode (01..12, reset 12:00); the default is 24-hour mode (00..23, reset 00:00).
module time_counter (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_minute,
    input  logic       load_new_c,
    input  logic [3:0] new_current_time_ms_hr,
    input  logic [3:0] new_current_time_ls_hr,
    input  logic [3:0] new_current_time_ms_min,
    input  logic [3:0] new_current_time_ls_min,
    output logic [3:0] current_time_ms_hr,
    output logic [3:0] current_time_ls_hr,
    output logic [3:0] current_time_ms_min,
    output logic [3:0] current_time_ls_min,
    output logic       load_err,
    output logic       day_wrap
);

`ifdef TIME_12HR_EN
    localparam logic [3:0] RST_MS_HR = 4'd1;
    localparam logic [3:0] RST_LS_HR = 4'd2;
`else
    localparam logic [3:0] RST_MS_HR = 4'd0;
    localparam logic [3:0] RST_LS_HR = 4'd0;
`endif

    logic [3:0] ms_hr_q, ls_hr_q, ms_min_q, ls_min_q;
    logic [3:0] ms_hr_d, ls_hr_d, ms_min_d, ls_min_d;
    logic       load_err_q, load_err_d;
    logic       day_wrap_q, day_wrap_d;

    function automatic logic time_valid(input logic [3:0] mh, input logic [3:0] lh,
                                        input logic [3:0] mm, input logic [3:0] lm);
        logic ok;
        ok = (mh <= 4'd9) && (lh <= 4'd9) && (mm <= 4'd5) && (lm <= 4'd9);
`ifdef TIME_12HR_EN
        ok = ok && (((mh == 4'd0) && (lh != 4'd0)) || ((mh == 4'd1) && (lh <= 4'd2)));
`else
        ok = ok && ((mh <= 4'd1) || ((mh == 4'd2) && (lh <= 4'd3)));
`endif
        return ok;
    endfunction

    // Strobes are level-sampled each edge: load_new_c beats one_minute, and a lost tick is dropped.
    always_comb begin
        ms_hr_d    = ms_hr_q;
        ls_hr_d    = ls_hr_q;
        ms_min_d   = ms_min_q;
        ls_min_d   = ls_min_q;
        load_err_d = 1'b0;
        day_wrap_d = 1'b0;
        if (load_new_c) begin
            if (time_valid(new_current_time_ms_hr, new_current_time_ls_hr,
                           new_current_time_ms_min, new_current_time_ls_min)) begin
                ms_hr_d  = new_current_time_ms_hr;
                ls_hr_d  = new_current_time_ls_hr;
                ms_min_d = new_current_time_ms_min;
                ls_min_d = new_current_time_ls_min;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (one_minute) begin
            if (!time_valid(ms_hr_q, ls_hr_q, ms_min_q, ls_min_q)) begin
                // Corrupted state recovers silently to the reset time.
                ms_hr_d  = RST_MS_HR;
                ls_hr_d  = RST_LS_HR;
                ms_min_d = 4'd0;
                ls_min_d = 4'd0;
            end else if (ls_min_q != 4'd9) begin
                ls_min_d = ls_min_q + 4'd1;
            end else begin
                ls_min_d = 4'd0;
                if (ms_min_q != 4'd5) begin
                    ms_min_d = ms_min_q + 4'd1;
                end else begin
                    ms_min_d = 4'd0;
`ifdef TIME_12HR_EN
                    if ((ms_hr_q == 4'd1) && (ls_hr_q == 4'd2)) begin
                        ms_hr_d    = 4'd0;
                        ls_hr_d    = 4'd1;
                        day_wrap_d = 1'b1;
                    end else
`else
                    if ((ms_hr_q == 4'd2) && (ls_hr_q == 4'd3)) begin
                        ms_hr_d    = 4'd0;
                        ls_hr_d    = 4'd0;
                        day_wrap_d = 1'b1;
                    end else
`endif
                    if (ls_hr_q == 4'd9) begin
                        ls_hr_d = 4'd0;
                        ms_hr_d = ms_hr_q + 4'd1;
                    end else begin
                        ls_hr_d = ls_hr_q + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ms_hr_q    <= RST_MS_HR;
            ls_hr_q    <= RST_LS_HR;
            ms_min_q   <= 4'd0;
            ls_min_q   <= 4'd0;
            load_err_q <= 1'b0;
            day_wrap_q <= 1'b0;
        end else begin
            ms_hr_q    <= ms_hr_d;
            ls_hr_q    <= ls_hr_d;
            ms_min_q   <= ms_min_d;
            ls_min_q   <= ls_min_d;
            load_err_q <= load_err_d;
            day_wrap_q <= day_wrap_d;
        end
    end

    assign current_time_ms_hr  = ms_hr_q;
    assign current_time_ls_hr  = ls_hr_q;
    assign current_time_ms_min = ms_min_q;
    assign current_time_ls_min = ls_min_q;
    assign load_err            = load_err_q;
    assign day_wrap            = day_wrap_q;

endmodule

// File: tb/tb_time_counter.sv
// Self-checking bench for time_counter; tracks time as a minute index and compares digits and pulses.
// Builds for either hour format, following TIME_12HR_EN.
module tb_time_counter;

`ifdef TIME_12HR_EN
    localparam int HR_BASE = 1;
    localparam int PERIOD  = 720;
    localparam int RST_IDX = 660;
    localparam int HR_LO   = 1;
    localparam int HR_HI   = 12;
`else
    localparam int HR_BASE = 0;
    localparam int PERIOD  = 1440;
    localparam int RST_IDX = 0;
    localparam int HR_LO   = 0;
    localparam int HR_HI   = 23;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       one_minute = 1'b0;
    logic       load_new_c = 1'b0;
    logic [3:0] n_mh = 4'd0, n_lh = 4'd0, n_mm = 4'd0, n_lm = 4'd0;
    logic [3:0] c_mh, c_lh, c_mm, c_lm;
    logic       load_err, day_wrap;

    logic [17:0] exp_q[$];
    int n_checks = 0;
    int n_fails  = 0;
    int cur_idx;

    time_counter dut (
        .clock                  (clock),
        .reset                  (reset),
        .one_minute             (one_minute),
        .load_new_c             (load_new_c),
        .new_current_time_ms_hr (n_mh),
        .new_current_time_ls_hr (n_lh),
        .new_current_time_ms_min(n_mm),
        .new_current_time_ls_min(n_lm),
        .current_time_ms_hr     (c_mh),
        .current_time_ls_hr     (c_lh),
        .current_time_ms_min    (c_mm),
        .current_time_ls_min    (c_lm),
        .load_err               (load_err),
        .day_wrap               (day_wrap)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] idx_to_bcd(input int idx);
        int h, m;
        h = idx / 60 + HR_BASE;
        m = idx % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    function automatic logic [17:0] observed();
        return {c_mh, c_lh, c_mm, c_lm, load_err, day_wrap};
    endfunction

    task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got time %h err %b wrap %b, expected time %h err %b wrap %b",
                     tag, obs[17:2], obs[1], obs[0], exp[17:2], exp[1], exp[0]);
        end
    endtask

    // One clock of stimulus; the scoreboard head is compared just after the edge.
    task automatic cycle(input string tag, input logic ld, input logic tk, input logic [15:0] dig);
        logic [17:0] e;
        @(negedge clock);
        load_new_c = ld;
        one_minute = tk;
        {n_mh, n_lh, n_mm, n_lm} = dig;
        @(posedge clock);
        #1;
        load_new_c = 1'b0;
        one_minute = 1'b0;
        e = exp_q.pop_front();
        check(tag, observed(), e);
    endtask

    task automatic do_load(input string tag, input logic [15:0] dig, input logic tk);
        int h, m;
        logic ok;
        h  = int'(dig[15:12]) * 10 + int'(dig[11:8]);
        m  = int'(dig[7:4]) * 10 + int'(dig[3:0]);
        ok = (dig[15:12] <= 9) && (dig[11:8] <= 9) && (dig[7:4] <= 5) && (dig[3:0] <= 9)
             && (h >= HR_LO) && (h <= HR_HI);
        if (ok) cur_idx = (h - HR_BASE) * 60 + m;
        exp_q.push_back({idx_to_bcd(cur_idx), !ok, 1'b0});
        cycle(tag, 1'b1, tk, dig);
    endtask

    task automatic do_tick(input string tag);
        cur_idx = (cur_idx + 1) % PERIOD;
        exp_q.push_back({idx_to_bcd(cur_idx), 1'b0, cur_idx == 0});
        cycle(tag, 1'b0, 1'b1, 16'($urandom_range(0, 65535)));
    endtask

    task automatic do_idle(input string tag);
        exp_q.push_back({idx_to_bcd(cur_idx), 2'b00});
        cycle(tag, 1'b0, 1'b0, 16'($urandom_range(0, 65535)));
    endtask

    initial begin
        cur_idx = RST_IDX;
        #12;
        check("reset_held", observed(), {idx_to_bcd(RST_IDX), 2'b00});
        @(negedge clock);
        reset = 1'b0;
        do_idle("after_reset");

        do_load("load_10_59", 16'h1059, 1'b0);
        do_tick("minute_carry");
`ifdef TIME_12HR_EN
        do_load("load_12_59", 16'h1259, 1'b0);
        do_tick("day_wrap_12");
        do_idle("wrap_one_cycle");
        do_load("load_09_59", 16'h0959, 1'b0);
        do_tick("digit_wrap_12");
        do_load("load_00_00_bad", 16'h0000, 1'b0);
`else
        do_load("load_19_59", 16'h1959, 1'b0);
        do_tick("hour_carry");
        do_load("load_23_59", 16'h2359, 1'b0);
        do_tick("day_wrap_24");
        do_idle("wrap_one_cycle");
        do_load("load_23_58", 16'h2358, 1'b0);
        do_tick("held_tick_1");
        do_tick("held_tick_2");
        do_tick("held_tick_3");
`endif
        do_load("bad_24_00", 16'h2400, 1'b0);
        do_idle("err_one_cycle");
        do_load("bad_07_60", 16'h0760, 1'b0);
        do_load("bad_0A_00", 16'h0A00, 1'b0);
        do_idle("after_bad");

        do_load("load_08_15", 16'h0815, 1'b0);
        do_load("collision", 16'h0630, 1'b1);
        do_tick("after_collision");

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0: do_load("rand_load", idx_to_bcd($urandom_range(0, PERIOD - 1)), 1'($urandom_range(0, 1)));
                1: do_load("rand_raw", 16'($urandom_range(0, 65535)), 1'b0);
                2: do_idle("rand_idle");
                default: do_tick("rand_tick");
            endcase
        end

        // Asynchronous reset mid-cycle, then a strobe that collides with reset.
        do_load("load_05_05", 16'h0505, 1'b0);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", observed(), {idx_to_bcd(RST_IDX), 2'b00});
        one_minute = 1'b1;
        load_new_c = 1'b1;
        @(posedge clock);
        #1;
        check("reset_beats_strobe", observed(), {idx_to_bcd(RST_IDX), 2'b00});
        one_minute = 1'b0;
        load_new_c = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        cur_idx = RST_IDX;
        do_tick("tick_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/time_counter.md
# time_counter

Current-time keeper for the alarm clock. It holds the time as four registered BCD digits and advances them by one minute on each `one_minute` strobe, with correct minute/hour carry and wrap-around. It also accepts a parallel load of a user-entered time. Its four digit outputs drive the `current_time_*` inputs of the four-digit LCD driver stage directly downstream.

## Interface
Parameters: none (the hour format is selected by macro; see Configuration).

- `clock` input 1: single system clock; all state updates on the rising edge
- `reset` input 1: asynchronous, active-high; clears all state immediately
- `one_minute` input 1: one-cycle strobe; advance time by one minute
- `load_new_c` input 1: one-cycle strobe; load the `new_current_time_*` digits
- `new_current_time_ms_hr` input 4: BCD tens-of-hours to load
- `new_current_time_ls_hr` input 4: BCD units-of-hours to load
- `new_current_time_ms_min` input 4: BCD tens-of-minutes to load
- `new_current_time_ls_min` input 4: BCD units-of-minutes to load
- `current_time_ms_hr` output 4: registered BCD tens-of-hours
- `current_time_ls_hr` output 4: registered BCD units-of-hours
- `current_time_ms_min` output 4: registered BCD tens-of-minutes
- `current_time_ls_min` output 4: registered BCD units-of-minutes
- `load_err` output 1: registered one-cycle pulse; a load was rejected as invalid
- `day_wrap` output 1: registered one-cycle pulse; the time wrapped to the start of day

## Operation
- **Priority per cycle:** `reset` > `load_new_c` > `one_minute`.
  - If `load_new_c` and `one_minute` are both high in the same cycle, the load wins and that tick is discarded, not deferred.
- **Load validation.** A load is accepted only if all of these hold:
  - every digit is 0..9;
  - `ms_min` is 0..5;
  - the hours value is in range: 00..23 in 24-hour mode, 01..12 in 12-hour mode.
- **Accepted load:** all four digits update together on that clock edge.
- **Rejected load:** time is held unchanged and `load_err` pulses for one cycle.
- **Increment chain on `one_minute`:**
  - `ls_min` counts 9 → 0 and carries into `ms_min`.
  - `ms_min` counts 5 → 0 and carries into hours.
  - Hours advance BCD: `ls_hr` 9 → 0 increments `ms_hr`.
- **Hour wrap:**
  - 24-hour mode: 23:59 → 00:00.
  - 12-hour mode: 12:59 → 01:00, and 09:59 → 10:00.
- **`day_wrap`:**
  - 24-hour mode: pulses on the tick that produces 00:00.
  - 12-hour mode: pulses on the tick that produces 01:00 from 12:59.
  - It never pulses because of a load.
- **State representation:** the digit registers are the only time state. There is no binary shadow copy, so the outputs are the registers themselves.
- **Invalid-state guard.** These states are unreachable, but behaviour is defined:
  - If the held time is ever out of range (e.g. after X-propagation in simulation is resolved), the next `one_minute` forces the reset time.
  - No `day_wrap` pulse accompanies that forced return.

## Timing
- **Reset values:**
  - 24-hour mode: all four digits = 0 (00:00).
  - 12-hour mode: time = 12:00.
  - `load_err` = 0 and `day_wrap` = 0.
- **Reset timing:** assertion takes effect asynchronously. Deassertion is synchronous in effect: the first edge after deassertion may process a strobe.
- **Latency:**
  - A strobe sampled on edge N updates the outputs at edge N, so they are visible in cycle N+1.
  - `load_err` and `day_wrap` are high for exactly the cycle following that edge.
- **Strobe width:** strobes are single-cycle. A strobe held high for K cycles acts as K events: K minute increments, or K reloads.
- **Reset mid-operation:** a reset asserted in the same cycle as any strobe discards the strobe. Outputs return to their reset values with no pulse.

## Configuration
- **`TIME_12HR_EN`**
  - Defined: 12-hour mode. Hours range 01..12, wrap 12:59 → 01:00, reset time 12:00, load accepts hours 01..12 only (00 is rejected).
  - Undefined (default): 24-hour mode. Hours 00..23, wrap 23:59 → 00:00, reset time 00:00.
- Port list is identical in both modes.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle → all digits 0 and `load_err` = `day_wrap` = 0 before the next edge (24-hour); 12:00 with `TIME_12HR_EN`.
- **Minute carry:** load 10:59, pulse `one_minute` → 11:00, `day_wrap` = 0.
- **Hour carry:** load 19:59, tick → 20:00.
- **Day wrap, 24-hour:** load 23:59, tick → 00:00 with a one-cycle `day_wrap` pulse.
- **Day wrap, 12-hour** (`TIME_12HR_EN`): load 12:59, tick → 01:00 with `day_wrap`.
- **Digit wrap, 12-hour:** 09:59 → 10:00 with no `day_wrap`.
- **Invalid loads:** load 24:00, then 07:60, then 0A:00 → each time is held, `load_err` pulses once each, `day_wrap` = 0.
- **Collision:** from 08:15, assert `load_new_c` (value 06:30) and `one_minute` in the same cycle → 06:30, not 06:31; the next tick alone gives 06:31.
